// File: rtl/fir_requant_decim.sv
// fir_requant_decim
//   Decimates a stream of 32-bit filter samples, requantises each kept sample
//   to 16 bits with round-half-up and saturation, and buffers the results in
//   a small output FIFO with valid/ready handshake.
//
// Parameters
//   DECIM : decimation factor (1..256); sample kept when phase counter is 0
//   SHIFT : right shift applied during requantisation (0..16)
//   DEPTH : output FIFO capacity in samples (power of 2, >= 2)
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   yn        : signed 32-bit input sample
//   in_valid  : yn valid this cycle
//   out_data  : signed 16-bit FIFO head
//   out_valid : FIFO not empty
//   out_ready : downstream accepts out_data (pop when out_valid & out_ready)
//   overflow  : sticky, a sample was dropped because the FIFO was full
//   sat_flag  : sticky, a kept sample was clamped (only with SAT_FLAG_EN)
//
// Build option
//   SAT_FLAG_EN : define to add the sat_flag output and its logic.
module fir_requant_decim #(
  parameter int unsigned DECIM = 4,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] yn,
  input  logic               in_valid,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overflow
`ifdef SAT_FLAG_EN
  ,
  output logic               sat_flag
`endif
);

  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic signed [32:0] RND = (SHIFT > 0) ? (33'sd1 <<< (SHIFT - 1)) : 33'sd0;

  // ---------------------------------------------------------------------------
  // Decimation phase
  // ---------------------------------------------------------------------------
  logic [PW-1:0] phase;
  logic          keep;

  assign keep = in_valid && (phase == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (in_valid) begin
      if (phase == PW'(DECIM - 1)) phase <= '0;
      else                         phase <= phase + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Requantisation: 33-bit round-half-up, arithmetic shift, saturate
  // ---------------------------------------------------------------------------
  logic signed [32:0] ext;
  logic signed [32:0] rounded;
  logic signed [32:0] shifted;
  logic signed [15:0] rq_next;
  logic               rq_sat;

  always_comb begin
    ext     = {yn[31], yn};
    rounded = ext + RND;
    shifted = rounded >>> SHIFT;
    rq_sat  = 1'b0;
    rq_next = shifted[15:0];
    if (shifted > 33'sd32767) begin
      rq_next = 16'sh7FFF;
      rq_sat  = 1'b1;
    end else if (shifted < -33'sd32768) begin
      rq_next = 16'sh8000;
      rq_sat  = 1'b1;
    end
  end

  logic signed [15:0] rq_data;
  logic               rq_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq_data  <= '0;
      rq_valid <= 1'b0;
    end else begin
      rq_valid <= keep;
      if (keep) rq_data <= rq_next;
    end
  end

`ifdef SAT_FLAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              sat_flag <= 1'b0;
    else if (keep && rq_sat) sat_flag <= 1'b1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO
  // The head lives in the out_data/out_valid register; the remaining entries
  // live in mem. Pushes always land in mem and the head refills from mem, so
  // total occupancy is mcnt + out_valid, capped at DEPTH. Writing into mem
  // rather than straight into the head gives the two-edge input-to-output
  // latency.
  // ---------------------------------------------------------------------------
  logic signed [15:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      mcnt;
  logic               pop;
  logic               full;
  logic               push;
  logic               drop;
  logic               load;

  always_comb begin
    pop  = out_valid && out_ready;
    full = out_valid && (mcnt == CW'(DEPTH - 1));
    push = rq_valid && (!full || pop);
    drop = rq_valid && full && !pop;
    load = (!out_valid || pop) && (mcnt != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rq_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mcnt      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      mcnt <= mcnt + CW'(push) - CW'(load);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule
